// File: rtl/mem_io_responder.sv
// Responder for the CPU byte bus: 2^RAM_AW byte RAM, UART tx/rx FIFOs, cycle counter and stop flag at 0x3xxxx.
// Optional macro CYCLE_LATCH_EN: a read of 0x30004 snapshots the counter so 0x30005-7 return a coherent word.
module mem_io_responder #(
  parameter int RAM_AW       = 17,
  parameter int TX_DEPTH_LOG = 4,
  parameter int RX_DEPTH_LOG = 4,
  parameter int FULL_MARGIN  = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_din,
  input  logic        mem_wr,
  input  logic        mem_rd,
  output logic [7:0]  mem_dout,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_finished,
  output logic        tx_overflow
);
  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG;
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG;
  localparam logic [TX_DEPTH_LOG:0] TX_FULL_CNT = (TX_DEPTH_LOG+1)'(TX_DEPTH);
  localparam logic [RX_DEPTH_LOG:0] RX_FULL_CNT = (RX_DEPTH_LOG+1)'(RX_DEPTH);

  logic [7:0] ram    [2**RAM_AW];
  logic [7:0] tx_mem [TX_DEPTH];
  logic [7:0] rx_mem [RX_DEPTH];

  logic [TX_DEPTH_LOG:0] tx_wp, tx_rp, tx_cnt, tx_wp_nxt, tx_rp_nxt, tx_cnt_nxt;
  logic [RX_DEPTH_LOG:0] rx_wp, rx_rp, rx_cnt;
  logic [31:0]           cycle_cnt;
  logic [7:0]            rd_byte_p0;
  logic                  is_io, rd_op, wr_op;
  logic [2:0]            io_off;
  logic [RAM_AW-1:0]     ram_addr;
  logic                  tx_full, tx_push_req, tx_push, tx_drop, tx_pop;
  logic                  rx_empty, rx_full, rx_push, rx_pop;
  logic                  fin_wr, io_full_nxt;
  logic                  unused_hi;

  // Write wins over a simultaneous read; the read is then dropped.
  assign wr_op     = mem_wr;
  assign rd_op     = mem_rd && !mem_wr;
  assign is_io     = (mem_a[17:16] == 2'b11);
  assign io_off    = mem_a[2:0];
  assign ram_addr  = mem_a[RAM_AW-1:0];
  assign unused_hi = ^mem_a[31:18];

  assign tx_cnt      = tx_wp - tx_rp;
  assign tx_full     = (tx_cnt == TX_FULL_CNT);
  assign tx_valid    = (tx_cnt != '0);
  assign tx_data     = tx_mem[tx_rp[TX_DEPTH_LOG-1:0]];
  assign tx_push_req = wr_op && is_io && (io_off == 3'd0) && (mem_din != 8'h00);
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_drop     = tx_push_req && tx_full;
  assign tx_pop      = tx_valid && tx_ready;
  assign fin_wr      = wr_op && is_io && (io_off == 3'd4);

  assign tx_wp_nxt   = tx_wp + (TX_DEPTH_LOG+1)'(tx_push);
  assign tx_rp_nxt   = tx_rp + (TX_DEPTH_LOG+1)'(tx_pop);
  assign tx_cnt_nxt  = tx_wp_nxt - tx_rp_nxt;
  assign io_full_nxt = (TX_DEPTH - int'(tx_cnt_nxt)) <= FULL_MARGIN;

  assign rx_cnt   = rx_wp - rx_rp;
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == RX_FULL_CNT);
  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && !rx_full;
  // Empty check uses the current count, so a same-cycle push is never bypassed.
  assign rx_pop   = rd_op && is_io && (io_off == 3'd0) && !rx_empty;

`ifdef CYCLE_LATCH_EN
  logic [31:0] cnt_snap_p1;

  always_ff @(posedge clk_in) begin
    if (rd_op && is_io && (io_off == 3'd4)) cnt_snap_p1 <= cycle_cnt;
  end
`endif

  always_comb begin
    rd_byte_p0 = 8'h00;
    if (!is_io) begin
      rd_byte_p0 = ram[ram_addr];
    end else begin
      case (io_off)
        3'd0: if (!rx_empty) rd_byte_p0 = rx_mem[rx_rp[RX_DEPTH_LOG-1:0]];
        3'd4: rd_byte_p0 = cycle_cnt[7:0];
`ifdef CYCLE_LATCH_EN
        3'd5: rd_byte_p0 = cnt_snap_p1[15:8];
        3'd6: rd_byte_p0 = cnt_snap_p1[23:16];
        3'd7: rd_byte_p0 = cnt_snap_p1[31:24];
`else
        3'd5: rd_byte_p0 = cycle_cnt[15:8];
        3'd6: rd_byte_p0 = cycle_cnt[23:16];
        3'd7: rd_byte_p0 = cycle_cnt[31:24];
`endif
        default: rd_byte_p0 = 8'h00;
      endcase
    end
  end

  // Storage arrays: data only, never reset.
  always_ff @(posedge clk_in) begin
    if (wr_op && !is_io) ram[ram_addr] <= mem_din;
    if (tx_push) tx_mem[tx_wp[TX_DEPTH_LOG-1:0]] <= mem_din;
    if (rx_push) rx_mem[rx_wp[RX_DEPTH_LOG-1:0]] <= rx_data;
  end

  // Stage p1: registered read return and control state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_wp            <= '0;
      tx_rp            <= '0;
      rx_wp            <= '0;
      rx_rp            <= '0;
      cycle_cnt        <= 32'd0;
      mem_dout         <= 8'h00;
      io_buffer_full   <= 1'b0;
      program_finished <= 1'b0;
      tx_overflow      <= 1'b0;
    end else begin
      tx_wp          <= tx_wp_nxt;
      tx_rp          <= tx_rp_nxt;
      rx_wp          <= rx_wp + (RX_DEPTH_LOG+1)'(rx_push);
      rx_rp          <= rx_rp + (RX_DEPTH_LOG+1)'(rx_pop);
      cycle_cnt      <= cycle_cnt + 32'd1;
      io_buffer_full <= io_full_nxt;
      if (rd_op)   mem_dout         <= rd_byte_p0;
      if (tx_drop) tx_overflow      <= 1'b1;
      if (fin_wr)  program_finished <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder: RAM, tx/rx FIFOs, cycle counter, stop flag and reset.
module tb_mem_io_responder;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] mem_a = '0;
  logic [7:0]  mem_din = '0;
  logic        mem_wr = 1'b0;
  logic        mem_rd = 1'b0;
  logic [7:0]  mem_dout;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        program_finished;
  logic        tx_overflow;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_cnt = '0;
  logic [31:0] exp_snap = '0;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_din(mem_din),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_dout(mem_dout),
    .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .program_finished(program_finished), .tx_overflow(tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  // One clock edge; the bench's own counter model follows the DUT's reset rule.
  task automatic step();
    @(posedge clk_in);
    if (rst_in) exp_cnt = 32'd0;
    else exp_cnt = exp_cnt + 32'd1;
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    mem_a = a; mem_din = d; mem_wr = 1'b1; mem_rd = 1'b0;
    step();
    mem_wr = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    mem_a = a; mem_rd = 1'b1; mem_wr = 1'b0;
    step();
    mem_rd = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
  endtask

  // Reads one counter byte at offset 4..7 and compares with the model.
  task automatic rd_cnt(input logic [31:0] a, input string name);
    logic [31:0] src;
    logic [2:0]  off;
    logic [7:0]  e;
    off = a[2:0];
`ifdef CYCLE_LATCH_EN
    if (off == 3'd4) exp_snap = exp_cnt;
    src = (off == 3'd4) ? exp_cnt : exp_snap;
`else
    src = exp_cnt;
`endif
    e = 8'(src >> (8 * (int'(off) - 4)));
    rd(a);
    n_checks++;
    if (mem_dout !== e) begin
      n_fail++;
      $display("FAIL %s: mem_dout=%h expected=%h", name, mem_dout, e);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    step();
    step();
    n_checks++; if (mem_dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got=%h exp=00", mem_dout); end
    n_checks++; if (program_finished !== 1'b0) begin n_fail++; $display("FAIL reset_fin: got=%b exp=0", program_finished); end
    n_checks++; if (tx_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got=%b exp=0", tx_overflow); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_txv: got=%b exp=0", tx_valid); end
    n_checks++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got=%b exp=0", io_buffer_full); end
    n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rxr: got=%b exp=1", rx_ready); end
    rst_in = 1'b0;
  endtask

  task automatic test_ram();
    wr(32'h0000_0010, 8'hA5);
    n_checks++; if (mem_dout !== 8'h00) begin n_fail++; $display("FAIL ram_wr_no_dout: got=%h exp=00", mem_dout); end
    rd(32'h0000_0010);
    n_checks++; if (mem_dout !== 8'hA5) begin n_fail++; $display("FAIL ram_rd_after_wr: got=%h exp=a5", mem_dout); end
    wr(32'h0000_0011, 8'h3C);
    wr(32'h0000_0012, 8'h7E);
    rd(32'h0000_0011);
    n_checks++; if (mem_dout !== 8'h3C) begin n_fail++; $display("FAIL ram_b2b_0: got=%h exp=3c", mem_dout); end
    mem_rd = 1'b1; mem_a = 32'h0000_0012;
    step();
    n_checks++; if (mem_dout !== 8'h7E) begin n_fail++; $display("FAIL ram_b2b_1: got=%h exp=7e", mem_dout); end
    mem_a = 32'h0000_0010;
    step();
    mem_rd = 1'b0;
    n_checks++; if (mem_dout !== 8'hA5) begin n_fail++; $display("FAIL ram_b2b_2: got=%h exp=a5", mem_dout); end
    step();
    n_checks++; if (mem_dout !== 8'hA5) begin n_fail++; $display("FAIL ram_hold: got=%h exp=a5", mem_dout); end
    mem_a = 32'h0000_0011; mem_din = 8'h99; mem_wr = 1'b1; mem_rd = 1'b1;
    step();
    mem_wr = 1'b0; mem_rd = 1'b0;
    n_checks++; if (mem_dout !== 8'hA5) begin n_fail++; $display("FAIL ram_wr_rd_hold: got=%h exp=a5", mem_dout); end
    rd(32'h0000_0011);
    n_checks++; if (mem_dout !== 8'h99) begin n_fail++; $display("FAIL ram_wr_rd_data: got=%h exp=99", mem_dout); end
  endtask

  task automatic test_tx();
    tx_ready = 1'b0;
    wr(32'h0003_0000, 8'h48);
    wr(32'h0003_0000, 8'h69);
    wr(32'h0003_0000, 8'h00);
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL tx_valid_q: got=%b exp=1", tx_valid); end
    n_checks++; if (tx_data !== 8'h48) begin n_fail++; $display("FAIL tx_head_h: got=%h exp=48", tx_data); end
    tx_ready = 1'b1;
    step();
    n_checks++; if (tx_data !== 8'h69 || tx_valid !== 1'b1) begin n_fail++; $display("FAIL tx_head_i: got=%h/%b exp=69/1", tx_data, tx_valid); end
    step();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_zero_dropped: valid=%b exp=0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_tx_full();
    tx_ready = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      wr(32'h0003_0000, 8'(k));
      n_checks++;
      if (io_buffer_full !== (k >= 14)) begin
        n_fail++; $display("FAIL tx_full_w%0d: io_buffer_full=%b exp=%b", k, io_buffer_full, (k >= 14));
      end
      n_checks++;
      if (tx_overflow !== (k >= 17)) begin
        n_fail++; $display("FAIL tx_ovf_w%0d: tx_overflow=%b exp=%b", k, tx_overflow, (k >= 17));
      end
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(i + 1)) begin
        n_fail++; $display("FAIL tx_drain_%0d: data=%h valid=%b exp=%h/1", i, tx_data, tx_valid, 8'(i + 1));
      end
      step();
    end
    tx_ready = 1'b0;
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drained: valid=%b exp=0", tx_valid); end
    n_checks++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL tx_full_clear: got=%b exp=0", io_buffer_full); end
    n_checks++; if (tx_overflow !== 1'b1) begin n_fail++; $display("FAIL tx_ovf_sticky: got=%b exp=1", tx_overflow); end
  endtask

  task automatic test_rx();
    rx_data = 8'h41; rx_valid = 1'b1;
    rd(32'h0003_0000);
    rx_valid = 1'b0;
    n_checks++; if (mem_dout !== 8'h00) begin n_fail++; $display("FAIL rx_no_bypass: got=%h exp=00", mem_dout); end
    rd(32'h0003_0000);
    n_checks++; if (mem_dout !== 8'h41) begin n_fail++; $display("FAIL rx_pop: got=%h exp=41", mem_dout); end
    rd(32'h0003_0000);
    n_checks++; if (mem_dout !== 8'h00) begin n_fail++; $display("FAIL rx_empty: got=%h exp=00", mem_dout); end
    for (int i = 0; i < 17; i++) begin
      rx_data = 8'(8'h80 + i); rx_valid = 1'b1;
      step();
    end
    rx_valid = 1'b0;
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_full: rx_ready=%b exp=0", rx_ready); end
    for (int i = 0; i < 16; i++) begin
      rd(32'h0003_0000);
      n_checks++;
      if (mem_dout !== 8'(8'h80 + i)) begin
        n_fail++; $display("FAIL rx_seq_%0d: got=%h exp=%h", i, mem_dout, 8'(8'h80 + i));
      end
    end
    rd(32'h0003_0000);
    n_checks++; if (mem_dout !== 8'h00) begin n_fail++; $display("FAIL rx_17th_dropped: got=%h exp=00", mem_dout); end
    n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_ready_back: got=%b exp=1", rx_ready); end
  endtask

  task automatic test_cycle_counter();
    do_reset();
    repeat (300) step();
    rd_cnt(32'h0003_0004, "cnt300_b0");
    rd_cnt(32'h0003_0005, "cnt300_b1");
    rd_cnt(32'h0003_0006, "cnt300_b2");
    rd_cnt(32'h0003_0007, "cnt300_b3");
    while (exp_cnt != 32'h0000_01FF) step();
    rd_cnt(32'h0003_0004, "cnt1ff_b0");
    rd_cnt(32'h0003_0005, "cnt1ff_b1");
    rd_cnt(32'h0003_0006, "cnt1ff_b2");
    rd_cnt(32'h0003_0007, "cnt1ff_b3");
    rd_cnt(32'h0003_FFF4, "cnt_alias_b0");
    rd(32'h0003_0001);
    n_checks++; if (mem_dout !== 8'h00) begin n_fail++; $display("FAIL io_unmapped_rd: got=%h exp=00", mem_dout); end
  endtask

  task automatic test_finish_reset();
    wr(32'h0003_0002, 8'h33);
    n_checks++; if (program_finished !== 1'b0 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL io_other_wr: fin=%b txv=%b exp=0/0", program_finished, tx_valid); end
    tx_ready = 1'b0;
    wr(32'h0003_0000, 8'h55);
    wr(32'h0003_0004, 8'h01);
    n_checks++; if (program_finished !== 1'b1) begin n_fail++; $display("FAIL fin_set: got=%b exp=1", program_finished); end
    tx_ready = 1'b1;
    step();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL fin_tx_drain: txv=%b exp=0", tx_valid); end
    tx_ready = 1'b0;
    wr(32'h0003_0000, 8'h77);
    rx_data = 8'h5A; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rst_in = 1'b1; mem_a = 32'h0000_0010; mem_rd = 1'b1;
    step();
    rst_in = 1'b0; mem_rd = 1'b0;
    n_checks++; if (program_finished !== 1'b0) begin n_fail++; $display("FAIL fin_cleared: got=%b exp=0", program_finished); end
    n_checks++; if (mem_dout !== 8'h00) begin n_fail++; $display("FAIL rst_read_discard: got=%h exp=00", mem_dout); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_flush: txv=%b exp=0", tx_valid); end
    n_checks++; if (tx_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got=%b exp=0", tx_overflow); end
    rd(32'h0003_0000);
    n_checks++; if (mem_dout !== 8'h00) begin n_fail++; $display("FAIL rst_rx_flush: got=%h exp=00", mem_dout); end
    repeat (4) step();
    rd_cnt(32'h0003_0004, "cnt_restart");
    rd(32'h0000_0010);
    n_checks++; if (mem_dout !== 8'hA5) begin n_fail++; $display("FAIL ram_kept: got=%h exp=a5", mem_dout); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_tx();
    test_tx_full();
    test_rx();
    test_cycle_counter();
    test_finish_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
